// File: rtl/stateful_strobe_driver.sv
// Lane-write driver for the nibble/strobe latch block: drive field, wait setup, pulse strobe, hold.
// Optional readback compare enabled by defining STATEFUL_STROBE_DRIVER_READBACK_EN.
module stateful_strobe_driver #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_lane,
  input  logic [1:0] cmd_data,
  output logic [3:0] data_out,
  output logic [1:0] strobe,
  output logic       busy
`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
  ,
  input  logic [3:0] rb_data,
  output logic       rb_mismatch,
  output logic       rb_done
`endif
);

  if (SETUP_CYC == 0 || SETUP_CYC > 255) begin : g_bad_setup
    $error("SETUP_CYC must be in 1..255");
  end
  if (STROBE_CYC == 0 || STROBE_CYC > 255) begin : g_bad_strobe
    $error("STROBE_CYC must be in 1..255");
  end
  if (HOLD_CYC == 0 || HOLD_CYC > 255) begin : g_bad_hold
    $error("HOLD_CYC must be in 1..255");
  end

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lane_q, lane_d;
  logic [1:0] fdata_q, fdata_d;
  logic [3:0] dout_q, dout_d;
  logic [1:0] strobe_q, strobe_d;
  logic       ready_q, ready_d;
  logic [1:0] lane_onehot;

  assign lane_onehot = lane_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    fdata_d  = fdata_q;
    dout_d   = dout_q;
    strobe_d = 2'b00;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          lane_d  = cmd_lane;
          fdata_d = cmd_data;
          // Only the addressed field moves; the other lane keeps its value.
          dout_d  = cmd_lane ? {cmd_data, dout_q[1:0]} : {dout_q[3:2], cmd_data};
          cnt_d   = SETUP_LD;
          state_d = SETUP;
          ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d  = STROBE;
          strobe_d = lane_onehot;
          cnt_d    = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          strobe_d = lane_onehot;
          cnt_d    = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      lane_q   <= 1'b0;
      fdata_q  <= 2'b00;
      dout_q   <= 4'b0000;
      strobe_q <= 2'b00;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      fdata_q  <= fdata_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign data_out  = dout_q;
  assign strobe    = strobe_q;
  assign busy      = (state_q != IDLE);

`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
  logic       rb_done_q, rb_done_d;
  logic       rb_mismatch_q, rb_mismatch_d;
  logic [1:0] rb_field;

  assign rb_field = lane_q ? rb_data[3:2] : rb_data[1:0];

  // Compare on the last HOLD cycle, i.e. the HOLD->IDLE edge.
  always_comb begin
    rb_done_d     = (state_q == HOLD) && (cnt_q == 8'd0);
    rb_mismatch_d = rb_mismatch_q | (rb_done_d && (rb_field != fdata_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_done_q     <= 1'b0;
      rb_mismatch_q <= 1'b0;
    end else begin
      rb_done_q     <= rb_done_d;
      rb_mismatch_q <= rb_mismatch_d;
    end
  end

  assign rb_done     = rb_done_q;
  assign rb_mismatch = rb_mismatch_q;
`endif

endmodule

// File: tb/tb_stateful_strobe_driver.sv
// Self-checking bench for stateful_strobe_driver: vector table, reference model, corner sequences.
module tb_stateful_strobe_driver;
  localparam int S   = 2;
  localparam int ST  = 1;
  localparam int H   = 1;
  localparam int TOT = S + ST + H + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, cmd_lane, cmd_ready, busy;
  logic [1:0] cmd_data, strobe;
  logic [3:0] data_out;

  logic       rst4_n, valid4, lane4, ready4, busy4;
  logic [1:0] data4, strobe4;
  logic [3:0] dout4;

`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
  logic [3:0] lat, rb_data, rb_zero;
  logic       rb_force, rb_mismatch, rb_done, rbm4, rbd4;
  assign rb_zero = 4'b0000;
  assign rb_data = rb_force ? {2'b00, lat[1:0]} : lat;
  always @(posedge clk) begin
    if (!rst_n) lat <= 4'b0000;
    else begin
      if (strobe[0]) lat[1:0] <= data_out[1:0];
      if (strobe[1]) lat[3:2] <= data_out[3:2];
    end
  end
`endif

  stateful_strobe_driver dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lane(cmd_lane), .cmd_data(cmd_data), .data_out(data_out),
    .strobe(strobe), .busy(busy)
`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
    , .rb_data(rb_data), .rb_mismatch(rb_mismatch), .rb_done(rb_done)
`endif
  );

  stateful_strobe_driver #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(1)) dut4 (
    .clk(clk), .rst_n(rst4_n), .cmd_valid(valid4), .cmd_ready(ready4),
    .cmd_lane(lane4), .cmd_data(data4), .data_out(dout4),
    .strobe(strobe4), .busy(busy4)
`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
    , .rb_data(rb_zero), .rb_mismatch(rbm4), .rb_done(rbd4)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is described only by its age in cycles since acceptance.
  bit         m_busy;
  int         m_age;
  logic       m_lane;
  logic [3:0] m_data;
  logic [3:0] prev_dout;

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_lane = 1'b0;
    m_data = 4'b0000;
  endtask

  function automatic logic [1:0] m_strobe();
    if (m_busy && m_age >= S + 1 && m_age <= S + ST) return m_lane ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic step_model(input string tag);
    if (!rst_n) model_reset();
    else if (!m_busy) begin
      if (cmd_valid) begin
        m_lane = cmd_lane;
        if (cmd_lane) m_data[3:2] = cmd_data;
        else          m_data[1:0] = cmd_data;
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else begin
      m_age++;
      if (m_age == TOT) begin
        m_busy = 1'b0;
        m_age  = 0;
      end
    end
    prev_dout = data_out;
    @(posedge clk); #1;
    chk({tag, "_data"},   data_out,  m_data);
    chk({tag, "_strobe"}, strobe,    m_strobe());
    chk({tag, "_ready"},  cmd_ready, !m_busy);
    chk({tag, "_busy"},   busy,      m_busy);
    if (data_out !== prev_dout) chk({tag, "_strobe_at_dchg"}, strobe, 2'b00);
  endtask

  typedef struct {
    bit       v;
    bit       l;
    bit [1:0] d;
    bit [3:0] ed;
    bit [1:0] es;
    bit       er;
    bit       eb;
  } vec_t;

  function automatic vec_t mk(bit v, bit l, bit [1:0] d, bit [3:0] ed, bit [1:0] es, bit er, bit eb);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.ed = ed; t.es = es; t.er = er; t.eb = eb;
    return t;
  endfunction

  vec_t tbl[20];
  int   hs_cyc[$];

`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
  task automatic rb_write(input logic l, input logic [1:0] d, input string tag);
    bit seen;
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_lane = l; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rb_done) begin seen = 1'b1; break; end
    end
    chk({tag, "_rb_done_seen"}, seen, 1'b1);
  endtask
`endif

  initial begin
    tbl[0]  = mk(1, 0, 2'b01, 4'b0001, 2'b00, 0, 1);
    tbl[1]  = mk(0, 0, 2'b00, 4'b0001, 2'b00, 0, 1);
    tbl[2]  = mk(0, 0, 2'b00, 4'b0001, 2'b01, 0, 1);
    tbl[3]  = mk(0, 0, 2'b00, 4'b0001, 2'b00, 0, 1);
    tbl[4]  = mk(0, 0, 2'b00, 4'b0001, 2'b00, 1, 0);
    tbl[5]  = mk(1, 0, 2'b11, 4'b0011, 2'b00, 0, 1);
    tbl[6]  = mk(1, 1, 2'b10, 4'b0011, 2'b00, 0, 1);
    tbl[7]  = mk(0, 0, 2'b00, 4'b0011, 2'b01, 0, 1);
    tbl[8]  = mk(0, 0, 2'b00, 4'b0011, 2'b00, 0, 1);
    tbl[9]  = mk(0, 0, 2'b00, 4'b0011, 2'b00, 1, 0);
    tbl[10] = mk(1, 1, 2'b11, 4'b1111, 2'b00, 0, 1);
    tbl[11] = mk(0, 0, 2'b00, 4'b1111, 2'b00, 0, 1);
    tbl[12] = mk(0, 0, 2'b00, 4'b1111, 2'b10, 0, 1);
    tbl[13] = mk(0, 0, 2'b00, 4'b1111, 2'b00, 0, 1);
    tbl[14] = mk(0, 0, 2'b00, 4'b1111, 2'b00, 1, 0);
    tbl[15] = mk(1, 1, 2'b01, 4'b0111, 2'b00, 0, 1);
    tbl[16] = mk(0, 0, 2'b00, 4'b0111, 2'b00, 0, 1);
    tbl[17] = mk(0, 0, 2'b00, 4'b0111, 2'b10, 0, 1);
    tbl[18] = mk(0, 0, 2'b00, 4'b0111, 2'b00, 0, 1);
    tbl[19] = mk(0, 0, 2'b00, 4'b0111, 2'b00, 1, 0);

    rst_n = 1'b0; cmd_valid = 1'b1; cmd_lane = 1'b1; cmd_data = 2'b11;
    rst4_n = 1'b0; valid4 = 1'b0; lane4 = 1'b0; data4 = 2'b00;
`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
    rb_force = 1'b0;
`endif

    // Reset held with a command pending: nothing may be taken.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_data", data_out, 4'b0000);
      chk("rst_strobe", strobe, 2'b00);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Directed vectors: single write, ignored command while busy, field preservation.
    for (int i = 0; i < 20; i++) begin
      cmd_valid = tbl[i].v; cmd_lane = tbl[i].l; cmd_data = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_data", i), data_out, tbl[i].ed);
      chk($sformatf("vec%0d_strobe", i), strobe, tbl[i].es);
      chk($sformatf("vec%0d_ready", i), cmd_ready, tbl[i].er);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
    end
    cmd_valid = 1'b0;

    // Random stimulus against the model, with occasional resets.
    rst_n = 1'b0;
    step_model("rnd_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_lane  = $urandom_range(0, 1);
      cmd_data  = $urandom_range(0, 3);
      step_model("rnd");
    end
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < TOT; i++) step_model("drain");

    // Back-to-back: valid held high, expect acceptance every TOT cycles.
    cmd_valid = 1'b1;
    cmd_lane  = $urandom_range(0, 1);
    cmd_data  = $urandom_range(0, 3);
    for (int c = 0; c < 40 && hs_cyc.size() < 4; c++) begin
      bit hs;
      hs = !m_busy;
      step_model("b2b");
      if (hs) begin
        hs_cyc.push_back(c);
        cmd_lane = $urandom_range(0, 1);
        cmd_data = $urandom_range(0, 3);
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_count", hs_cyc.size(), 4);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("b2b_period", hs_cyc[i] - hs_cyc[i-1], TOT);
    for (int i = 0; i < TOT; i++) step_model("b2b_drain");

    // Reset in the middle of a 4-cycle strobe.
    @(posedge clk); #1;
    chk("r4_ready", ready4, 1'b1);
    chk("r4_dout", dout4, 4'b0000);
    rst4_n = 1'b1; valid4 = 1'b1; lane4 = 1'b1; data4 = 2'b10;
    @(posedge clk); #1;
    valid4 = 1'b0;
    chk("r4_dout_wr", dout4, 4'b1000);
    chk("r4_busy", busy4, 1'b1);
    @(posedge clk); #1;
    chk("r4_setup_strobe", strobe4, 2'b00);
    @(posedge clk); #1;
    chk("r4_strobe1", strobe4, 2'b10);
    @(posedge clk); #1;
    chk("r4_strobe2", strobe4, 2'b10);
    rst4_n = 1'b0;
    @(posedge clk); #1;
    chk("r4_abort_strobe", strobe4, 2'b00);
    chk("r4_abort_ready", ready4, 1'b1);
    chk("r4_abort_busy", busy4, 1'b0);
    chk("r4_abort_dout", dout4, 4'b0000);

`ifdef STATEFUL_STROBE_DRIVER_READBACK_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rb_rst_mm", rb_mismatch, 1'b0);
    rb_write(1'b1, 2'b10, "rb1");
    chk("rb1_mm", rb_mismatch, 1'b0);
    @(posedge clk); #1;
    chk("rb1_pulse_end", rb_done, 1'b0);
    rb_force = 1'b1;
    rb_write(1'b1, 2'b10, "rb2");
    chk("rb2_mm", rb_mismatch, 1'b1);
    rb_force = 1'b0;
    rb_write(1'b0, 2'b01, "rb3");
    chk("rb3_sticky", rb_mismatch, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rb_clr_mm", rb_mismatch, 1'b0);
    chk("rb_clr_done", rb_done, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
